zap_wb_arbiter: RTL and testbench

//  Parametrised N-master Wishbone B3 arbiter/mux. Merges the _nxt buses of N

---
 rtl/zap_wb_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_zap_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_wb_arbiter.sv
`timescale 1ns/1ps
// zap_wb_arbiter: N-master Wishbone B3 arbiter/mux with a registered slave
// bus, burst lock, fixed-priority or round-robin selection and a watchdog.
module zap_wb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_MASTERS-1:0]    i_m_cyc_nxt,
  input  logic [NUM_MASTERS-1:0]    i_m_stb_nxt,
  input  logic [NUM_MASTERS-1:0]    i_m_wen_nxt,
  input  logic [4*NUM_MASTERS-1:0]  i_m_sel_nxt,
  input  logic [32*NUM_MASTERS-1:0] i_m_adr_nxt,
  input  logic [32*NUM_MASTERS-1:0] i_m_dat_nxt,
  input  logic [3*NUM_MASTERS-1:0]  i_m_cti_nxt,
  output logic [NUM_MASTERS-1:0]    o_m_ack,
  output logic [NUM_MASTERS-1:0]    o_m_err,
  output logic [31:0]               o_m_dat,
  output logic [NUM_MASTERS-1:0]    o_grant,
  output logic                      o_timeout,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_wen,
  output logic [3:0]                o_wb_sel,
  output logic [31:0]               o_wb_adr,
  output logic [31:0]               o_wb_dat,
  output logic [2:0]                o_wb_cti,
  input  logic [31:0]               i_wb_dat,
  input  logic                      i_wb_ack,
  input  logic                      i_wb_err
);

  localparam int N  = NUM_MASTERS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [2:0] CTI_EOB = 3'b111;

  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, owner_idx, win_idx, grant_idx, cidx;
  logic          win_found, owner_cyc, slv_resp, arb_win, wd_fire;
  int            cand;

  logic        wb_cyc_q, wb_cyc_d, wb_stb_q, wb_stb_d, wb_wen_q, wb_wen_d;
  logic [3:0]  wb_sel_q, wb_sel_d;
  logic [31:0] wb_adr_q, wb_adr_d, wb_dat_q, wb_dat_d;
  logic [2:0]  wb_cti_q, wb_cti_d;

  assign slv_resp  = i_wb_ack | i_wb_err;
  assign owner_cyc = |(i_m_cyc_nxt & grant_q);
  // Grant may only move between bursts, after the last beat or when the owner lets go.
  assign arb_win   = !wb_cyc_q
                   | (wb_stb_q & slv_resp & (wb_cti_q == CTI_EOB))
                   | !owner_cyc;

  // Index of the current one-hot owner.
  always_comb begin
    owner_idx = '0;
    for (int k = 0; k < N; k++)
      if (grant_q[k]) owner_idx = IW'(k);
  end

  // Pick a winner: highest requesting index, or first requester after the last owner.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    cidx      = '0;
    if (ARB_MODE == 0) begin
      for (int k = 0; k < N; k++)
        if (i_m_cyc_nxt[k]) begin
          win_idx   = IW'(k);
          win_found = 1'b1;
        end
    end else begin
      for (int s = 1; s <= N; s++) begin
        cand = int'(rr_ptr_q) + s;
        if (cand >= N) cand = cand - N;
        cidx = IW'(cand);
        if (!win_found && i_m_cyc_nxt[cidx]) begin
          win_idx   = cidx;
          win_found = 1'b1;
        end
      end
    end
  end

  // Next owner; with nobody requesting the current grant is kept.
  always_comb begin
    grant_idx = (arb_win && win_found) ? win_idx : owner_idx;
    grant_d   = '0;
    for (int k = 0; k < N; k++)
      grant_d[k] = (IW'(k) == grant_idx);
  end

  // Mux the next owner's bus; a watchdog hit blanks cyc/stb for one cycle.
  always_comb begin
    wb_cyc_d = 1'b0;
    wb_stb_d = 1'b0;
    wb_wen_d = 1'b0;
    wb_sel_d = '0;
    wb_adr_d = '0;
    wb_dat_d = '0;
    wb_cti_d = CTI_EOB;
    for (int k = 0; k < N; k++)
      if (grant_d[k]) begin
        wb_cyc_d = i_m_cyc_nxt[k] & ~wd_fire;
        wb_stb_d = i_m_stb_nxt[k] & ~wd_fire;
        wb_wen_d = i_m_wen_nxt[k];
        wb_sel_d = i_m_sel_nxt[4*k +: 4];
        wb_adr_d = i_m_adr_nxt[32*k +: 32];
        wb_dat_d = i_m_dat_nxt[32*k +: 32];
        wb_cti_d = i_m_cti_nxt[3*k +: 3];
      end
  end

  // Registered grant, round-robin pointer and slave bus.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      grant_q  <= N'(1);
      rr_ptr_q <= '0;
      wb_cyc_q <= 1'b0;
      wb_stb_q <= 1'b0;
      wb_wen_q <= 1'b0;
      wb_sel_q <= '0;
      wb_adr_q <= '0;
      wb_dat_q <= '0;
      wb_cti_q <= CTI_EOB;
    end else begin
      grant_q <= grant_d;
      if (grant_d != grant_q) rr_ptr_q <= grant_idx;
      wb_cyc_q <= wb_cyc_d;
      wb_stb_q <= wb_stb_d;
      wb_wen_q <= wb_wen_d;
      wb_sel_q <= wb_sel_d;
      wb_adr_q <= wb_adr_d;
      wb_dat_q <= wb_dat_d;
      wb_cti_q <= wb_cti_d;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);
      logic [CW-1:0] wd_q, wd_d;

      // A real slave response in the same cycle takes precedence over the watchdog.
      assign wd_fire = wb_stb_q & ~slv_resp & (wd_q == WD_LAST);

      // Count consecutive stalled strobe cycles.
      always_comb begin
        wd_d = wd_q + CW'(1);
        if (!wb_stb_q || slv_resp || wd_fire) wd_d = '0;
      end

      // Watchdog counter register.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) wd_q <= '0;
        else            wd_q <= wd_d;
      end
    end else begin : g_no_wd
      assign wd_fire = 1'b0;
    end
  endgenerate

  // Route slave (or watchdog) responses to the registered owner only.
  always_comb begin
    o_m_ack = '0;
    o_m_err = '0;
    for (int k = 0; k < N; k++)
      if (grant_q[k]) begin
        o_m_ack[k] = slv_resp | wd_fire;
        o_m_err[k] = i_wb_err | wd_fire;
      end
  end

  assign o_m_dat   = i_wb_dat;
  assign o_grant   = grant_q;
  assign o_timeout = wd_fire;
  assign o_wb_cyc  = wb_cyc_q;
  assign o_wb_stb  = wb_stb_q;
  assign o_wb_wen  = wb_wen_q;
  assign o_wb_sel  = wb_sel_q;
  assign o_wb_adr  = wb_adr_q;
  assign o_wb_dat  = wb_dat_q;
  assign o_wb_cti  = wb_cti_q;

endmodule

// File: tb/tb_zap_wb_arbiter.sv
`timescale 1ns/1ps
// Directed bench: instance a is fixed priority with a 16-cycle watchdog,
// instance b is round robin with the watchdog disabled.
module tb_zap_wb_arbiter;

  localparam logic [2:0] EOB  = 3'b111;
  localparam logic [2:0] INCR = 3'b010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [3:0]   a_cyc, a_stb, a_wen, a_mack, a_merr, a_grant;
  logic [15:0]  a_sel;
  logic [127:0] a_adr, a_dat;
  logic [11:0]  a_cti;
  logic [31:0]  a_wbdat, a_mdat, a_wadr, a_wdat;
  logic         a_ack, a_err, a_timeout, a_wcyc, a_wstb, a_wwen;
  logic [3:0]   a_wsel;
  logic [2:0]   a_wcti;

  logic [3:0]   b_cyc, b_stb, b_wen, b_mack, b_merr, b_grant;
  logic [15:0]  b_sel;
  logic [127:0] b_adr, b_dat;
  logic [11:0]  b_cti;
  logic [31:0]  b_wbdat, b_mdat, b_wadr, b_wdat;
  logic         b_ack, b_err, b_timeout, b_wcyc, b_wstb, b_wwen;
  logic [3:0]   b_wsel;
  logic [2:0]   b_wcti;

  zap_wb_arbiter #(.NUM_MASTERS(4), .ARB_MODE(0), .TIMEOUT_CYCLES(16)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m_cyc_nxt(a_cyc), .i_m_stb_nxt(a_stb), .i_m_wen_nxt(a_wen),
    .i_m_sel_nxt(a_sel), .i_m_adr_nxt(a_adr), .i_m_dat_nxt(a_dat),
    .i_m_cti_nxt(a_cti),
    .o_m_ack(a_mack), .o_m_err(a_merr), .o_m_dat(a_mdat),
    .o_grant(a_grant), .o_timeout(a_timeout),
    .o_wb_cyc(a_wcyc), .o_wb_stb(a_wstb), .o_wb_wen(a_wwen),
    .o_wb_sel(a_wsel), .o_wb_adr(a_wadr), .o_wb_dat(a_wdat),
    .o_wb_cti(a_wcti),
    .i_wb_dat(a_wbdat), .i_wb_ack(a_ack), .i_wb_err(a_err)
  );

  zap_wb_arbiter #(.NUM_MASTERS(4), .ARB_MODE(1), .TIMEOUT_CYCLES(0)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m_cyc_nxt(b_cyc), .i_m_stb_nxt(b_stb), .i_m_wen_nxt(b_wen),
    .i_m_sel_nxt(b_sel), .i_m_adr_nxt(b_adr), .i_m_dat_nxt(b_dat),
    .i_m_cti_nxt(b_cti),
    .o_m_ack(b_mack), .o_m_err(b_merr), .o_m_dat(b_mdat),
    .o_grant(b_grant), .o_timeout(b_timeout),
    .o_wb_cyc(b_wcyc), .o_wb_stb(b_wstb), .o_wb_wen(b_wwen),
    .o_wb_sel(b_wsel), .o_wb_adr(b_wadr), .o_wb_dat(b_wdat),
    .o_wb_cti(b_wcti),
    .i_wb_dat(b_wbdat), .i_wb_ack(b_ack), .i_wb_err(b_err)
  );

  task automatic drive_a(input int k, input logic req, input logic [2:0] cti,
                         input logic [31:0] adr, input logic wen,
                         input logic [3:0] sel, input logic [31:0] dat);
    a_cyc[k] = req;
    a_stb[k] = req;
    a_wen[k] = wen;
    a_sel[4*k +: 4]   = sel;
    a_adr[32*k +: 32] = adr;
    a_dat[32*k +: 32] = dat;
    a_cti[3*k +: 3]   = cti;
  endtask

  task automatic drive_b(input int k, input logic req, input logic [31:0] adr);
    b_cyc[k] = req;
    b_stb[k] = req;
    b_wen[k] = 1'b0;
    b_sel[4*k +: 4]   = 4'hF;
    b_adr[32*k +: 32] = adr;
    b_dat[32*k +: 32] = 32'h0;
    b_cti[3*k +: 3]   = EOB;
  endtask

  task automatic test_reset;
    a_cyc = '0; a_stb = '0; a_wen = '0; a_sel = '0; a_adr = '0; a_dat = '0;
    a_cti = '0; a_wbdat = '0; a_ack = 1'b0; a_err = 1'b0;
    b_cyc = '0; b_stb = '0; b_wen = '0; b_sel = '0; b_adr = '0; b_dat = '0;
    b_cti = '0; b_wbdat = '0; b_ack = 1'b0; b_err = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (a_grant !== 4'b0001) $display("FAIL rst_grant: got %b want 0001", a_grant); else passed++;
    checks++; if ({a_wcyc, a_wstb, a_wwen} !== 3'b000) $display("FAIL rst_ctl: got %b want 000", {a_wcyc, a_wstb, a_wwen}); else passed++;
    checks++; if ({a_wsel, a_wadr, a_wdat} !== 68'h0) $display("FAIL rst_data: got sel %h adr %h dat %h want 0", a_wsel, a_wadr, a_wdat); else passed++;
    checks++; if (a_wcti !== EOB) $display("FAIL rst_cti: got %b want 111", a_wcti); else passed++;
    checks++; if ({a_mack, a_merr, a_timeout} !== 9'h0) $display("FAIL rst_resp: got %b want 0", {a_mack, a_merr, a_timeout}); else passed++;
    checks++; if (b_grant !== 4'b0001) $display("FAIL rst_grant_rr: got %b want 0001", b_grant); else passed++;
    @(negedge clk); #1;
    checks++; if (a_grant !== 4'b0001 || a_wcyc !== 1'b0) $display("FAIL idle_hold: got grant %b cyc %b want 0001 0", a_grant, a_wcyc); else passed++;
  endtask

  task automatic test_fixed_priority;
    @(negedge clk);
    drive_a(0, 1'b1, EOB, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
    drive_a(2, 1'b1, EOB, 32'h0000_0200, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    @(negedge clk); #1;
    checks++; if (a_grant !== 4'b0100) $display("FAIL fp_grant: got %b want 0100", a_grant); else passed++;
    checks++; if ({a_wcyc, a_wstb, a_wwen} !== 3'b111) $display("FAIL fp_ctl: got %b want 111", {a_wcyc, a_wstb, a_wwen}); else passed++;
    checks++; if (a_wadr !== 32'h200 || a_wsel !== 4'b0011 || a_wdat !== 32'hDEAD_BEEF)
      $display("FAIL fp_bus: got adr %h sel %b dat %h want 200 0011 deadbeef", a_wadr, a_wsel, a_wdat); else passed++;
    checks++; if (a_mack !== 4'b0000) $display("FAIL fp_noack: got %b want 0000", a_mack); else passed++;
    a_ack = 1'b1; a_wbdat = 32'hCAFE_0001; #1;
    checks++; if (a_mack !== 4'b0100 || a_merr !== 4'b0000) $display("FAIL fp_ack2: got ack %b err %b want 0100 0000", a_mack, a_merr); else passed++;
    checks++; if (a_mdat !== 32'hCAFE_0001) $display("FAIL fp_rdat: got %h want cafe0001", a_mdat); else passed++;
    drive_a(2, 1'b0, EOB, 32'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk); a_ack = 1'b0; #1;
    checks++; if (a_grant !== 4'b0001) $display("FAIL fp_next: got %b want 0001", a_grant); else passed++;
    checks++; if (a_wadr !== 32'h100 || a_wwen !== 1'b0) $display("FAIL fp_bus0: got adr %h wen %b want 100 0", a_wadr, a_wwen); else passed++;
    a_ack = 1'b1; #1;
    checks++; if (a_mack !== 4'b0001) $display("FAIL fp_ack0: got %b want 0001", a_mack); else passed++;
    drive_a(0, 1'b0, EOB, 32'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk); a_ack = 1'b0; #1;
    checks++; if (a_wcyc !== 1'b0 || a_grant !== 4'b0001) $display("FAIL fp_idle: got cyc %b grant %b want 0 0001", a_wcyc, a_grant); else passed++;
  endtask

  task automatic test_burst_lock;
    int m3_acks;
    logic bad_grant, bad_adr, bad_ack;
    m3_acks = 0; bad_grant = 1'b0; bad_adr = 1'b0; bad_ack = 1'b0;
    @(negedge clk);
    drive_a(1, 1'b1, INCR, 32'h0000_1000, 1'b0, 4'hF, 32'h0);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk); a_ack = 1'b0;
      if (b == 2) drive_a(3, 1'b1, EOB, 32'h0000_3000, 1'b0, 4'hF, 32'h0);
      #1;
      if (a_grant !== 4'b0010) bad_grant = 1'b1;
      if (a_wadr !== 32'h1000 + 32'(4*b) || a_wcti !== ((b == 7) ? EOB : INCR)) bad_adr = 1'b1;
      a_ack = 1'b1; #1;
      if (a_mack[3]) m3_acks++;
      if (a_mack !== 4'b0010) bad_ack = 1'b1;
      if (b < 7) drive_a(1, 1'b1, (b + 1 == 7) ? EOB : INCR, 32'h1000 + 32'(4*(b+1)), 1'b0, 4'hF, 32'h0);
      else       drive_a(1, 1'b0, EOB, 32'h0, 1'b0, 4'h0, 32'h0);
    end
    checks++; if (bad_grant) $display("FAIL burst_grant: grant left 0010 during burst, last %b", a_grant); else passed++;
    checks++; if (bad_adr) $display("FAIL burst_beats: adr/cti sequence wrong, last adr %h cti %b", a_wadr, a_wcti); else passed++;
    checks++; if (bad_ack) $display("FAIL burst_ack: ack vector not 0010 during burst, last %b", a_mack); else passed++;
    checks++; if (m3_acks != 0) $display("FAIL burst_m3_acks: got %0d want 0", m3_acks); else passed++;
    @(negedge clk); a_ack = 1'b0; #1;
    checks++; if (a_grant !== 4'b1000 || a_wadr !== 32'h3000) $display("FAIL burst_handoff: got grant %b adr %h want 1000 3000", a_grant, a_wadr); else passed++;
    a_ack = 1'b1; #1;
    checks++; if (a_mack !== 4'b1000) $display("FAIL burst_m3_ack: got %b want 1000", a_mack); else passed++;
    drive_a(3, 1'b0, EOB, 32'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk); a_ack = 1'b0;
  endtask

  task automatic test_watchdog;
    logic early;
    early = 1'b0;
    @(negedge clk);
    drive_a(0, 1'b1, EOB, 32'h0000_0040, 1'b0, 4'hF, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin
        checks++; if (a_grant !== 4'b0001 || a_wstb !== 1'b1) $display("FAIL wd_start: got grant %b stb %b want 0001 1", a_grant, a_wstb); else passed++;
      end
      if (k < 16 && (a_timeout !== 1'b0 || a_merr !== 4'b0000)) early = 1'b1;
      if (k == 16) begin
        checks++; if (early) $display("FAIL wd_early: timeout seen before stb cycle 16"); else passed++;
        checks++; if (a_timeout !== 1'b1) $display("FAIL wd_fire: got %b want 1", a_timeout); else passed++;
        checks++; if (a_mack !== 4'b0001 || a_merr !== 4'b0001) $display("FAIL wd_resp: got ack %b err %b want 0001 0001", a_mack, a_merr); else passed++;
      end
    end
    @(negedge clk); #1;
    checks++; if (a_wstb !== 1'b0 || a_wcyc !== 1'b0 || a_timeout !== 1'b0) $display("FAIL wd_force: got stb %b cyc %b to %b want 0 0 0", a_wstb, a_wcyc, a_timeout); else passed++;
    early = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 16) a_ack = 1'b1;
      #1;
      if (k == 1) begin
        checks++; if (a_wstb !== 1'b1) $display("FAIL wd_retry: got stb %b want 1", a_wstb); else passed++;
      end
      if (k < 16 && a_timeout !== 1'b0) early = 1'b1;
      if (k == 16) begin
        checks++; if (early) $display("FAIL wd_early2: timeout seen before stb cycle 16"); else passed++;
        checks++; if (a_timeout !== 1'b0 || a_merr !== 4'b0000 || a_mack !== 4'b0001)
          $display("FAIL wd_ack_wins: got to %b err %b ack %b want 0 0000 0001", a_timeout, a_merr, a_mack); else passed++;
        drive_a(0, 1'b0, EOB, 32'h0, 1'b0, 4'h0, 32'h0);
      end
    end
    @(negedge clk); a_ack = 1'b0;
  endtask

  task automatic test_err_only;
    @(negedge clk);
    drive_a(2, 1'b1, EOB, 32'h0000_2220, 1'b0, 4'hF, 32'h0);
    @(negedge clk); #1;
    checks++; if (a_grant !== 4'b0100 || a_wwen !== 1'b0 || a_wadr !== 32'h2220) $display("FAIL err_req: got grant %b wen %b adr %h want 0100 0 2220", a_grant, a_wwen, a_wadr); else passed++;
    a_err = 1'b1; a_wbdat = 32'h5A5A_1234; #1;
    checks++; if (a_mack !== 4'b0100 || a_merr !== 4'b0100) $display("FAIL err_resp: got ack %b err %b want 0100 0100", a_mack, a_merr); else passed++;
    checks++; if (a_mdat !== 32'h5A5A_1234 || a_timeout !== 1'b0) $display("FAIL err_rdat: got %h to %b want 5a5a1234 0", a_mdat, a_timeout); else passed++;
    drive_a(2, 1'b0, EOB, 32'h0, 1'b0, 4'h0, 32'h0);
    drive_a(0, 1'b1, EOB, 32'h0000_0044, 1'b0, 4'hF, 32'h0);
    @(negedge clk); a_err = 1'b0; #1;
    checks++; if (a_grant !== 4'b0001 || a_wadr !== 32'h44) $display("FAIL err_next: got grant %b adr %h want 0001 44", a_grant, a_wadr); else passed++;
    a_ack = 1'b1; #1;
    drive_a(0, 1'b0, EOB, 32'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk); a_ack = 1'b0;
  endtask

  task automatic test_round_robin;
    int exp_idx;
    @(negedge clk);
    for (int k = 0; k < 4; k++) drive_b(k, 1'b1, 32'h100 * 32'(k + 1));
    for (int i = 0; i < 5; i++) begin
      exp_idx = (i + 1) % 4;
      @(negedge clk); b_ack = 1'b0; #1;
      checks++; if (b_grant !== 4'(1 << exp_idx) || b_wadr !== 32'h100 * 32'(exp_idx + 1))
        $display("FAIL rr_grant_%0d: got grant %b adr %h want %b %h", i, b_grant, b_wadr, 4'(1 << exp_idx), 32'h100 * 32'(exp_idx + 1)); else passed++;
      b_ack = 1'b1; #1;
      checks++; if (b_mack !== 4'(1 << exp_idx)) $display("FAIL rr_ack_%0d: got %b want %b", i, b_mack, 4'(1 << exp_idx)); else passed++;
    end
    for (int k = 0; k < 4; k++) drive_b(k, 1'b0, 32'h0);
    @(negedge clk); b_ack = 1'b0;
  endtask

  task automatic test_reset_mid_burst;
    @(negedge clk);
    drive_a(1, 1'b1, INCR, 32'h0000_8000, 1'b1, 4'hF, 32'h1234_5678);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); a_ack = 1'b1; #1;
      drive_a(1, 1'b1, INCR, 32'h8000 + 32'(4*(b+1)), 1'b1, 4'hF, 32'h1234_5678);
    end
    @(negedge clk); a_ack = 1'b0; #1;
    checks++; if (a_wcyc !== 1'b1 || a_grant !== 4'b0010 || a_wadr !== 32'h8008) $display("FAIL mid_pre: got cyc %b grant %b adr %h want 1 0010 8008", a_wcyc, a_grant, a_wadr); else passed++;
    #1 rst_n = 1'b0; a_ack = 1'b1; #1;
    checks++; if (a_wcyc !== 1'b0 || a_wstb !== 1'b0) $display("FAIL mid_rst_ctl: got cyc %b stb %b want 0 0", a_wcyc, a_wstb); else passed++;
    checks++; if (a_grant !== 4'b0001 || a_wcti !== EOB || a_wadr !== 32'h0) $display("FAIL mid_rst_bus: got grant %b cti %b adr %h want 0001 111 0", a_grant, a_wcti, a_wadr); else passed++;
    checks++; if (a_mack[1] !== 1'b0 || a_timeout !== 1'b0) $display("FAIL mid_rst_resp: got ack1 %b to %b want 0 0", a_mack[1], a_timeout); else passed++;
    a_ack = 1'b0;
    drive_a(1, 1'b0, EOB, 32'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (a_grant !== 4'b0001 || a_wcyc !== 1'b0) $display("FAIL mid_release: got grant %b cyc %b want 0001 0", a_grant, a_wcyc); else passed++;
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_burst_lock();
    test_watchdog();
    test_err_only();
    test_round_robin();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
